// File: rtl/pe_ctrl_pkg.sv
// Shared types for the PE matmul sequencer: FSM states, default widths and
// the configuration that is captured when a start is accepted.
package pe_ctrl_pkg;
  localparam int ADDR_W_DEF = 32;
  localparam int DIM_W_DEF  = 16;

  typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

  typedef struct packed {
    logic [DIM_W_DEF-1:0]  m;
    logic [DIM_W_DEF-1:0]  n;
    logic [DIM_W_DEF-1:0]  k;
    logic [ADDR_W_DEF-1:0] base_a;
    logic [ADDR_W_DEF-1:0] base_b;
    logic [ADDR_W_DEF-1:0] base_c;
  } cfg_t;

  function automatic logic any_zero(input logic [DIM_W_DEF-1:0] m, n, k);
    return (m == '0) || (n == '0) || (k == '0);
  endfunction
endpackage

// File: rtl/pe_matmul_sequencer_if.sv
// Host/PE-facing bundle of the sequencer. master drives the request and the
// step handshake; slave is the sequencer itself.
interface pe_matmul_sequencer_if import pe_ctrl_pkg::*; #(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DIM_W  = DIM_W_DEF
);
  logic              start;
  logic [DIM_W-1:0]  dim_m, dim_n, dim_k;
  logic [ADDR_W-1:0] base_a, base_b, base_c;
  logic              step_fin;
  logic              pe_active, pe_vec_fin;
  logic [ADDR_W-1:0] left_addr, right_addr, result_addr;
  logic              busy, done;

  modport master (
    output start, dim_m, dim_n, dim_k, base_a, base_b, base_c, step_fin,
    input  pe_active, pe_vec_fin, left_addr, right_addr, result_addr, busy, done
  );

  modport slave (
    input  start, dim_m, dim_n, dim_k, base_a, base_b, base_c, step_fin,
    output pe_active, pe_vec_fin, left_addr, right_addr, result_addr, busy, done
  );
endinterface

// File: rtl/pe_loop_counter.sv
// Nested i/j/k loop counter (k innermost) advancing once per enabled cycle,
// with last-index flags for the address logic and the FSM.
module pe_loop_counter #(
  parameter int DIM_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             en,
  input  logic [DIM_W-1:0] dim_m,
  input  logic [DIM_W-1:0] dim_n,
  input  logic [DIM_W-1:0] dim_k,
  output logic [DIM_W-1:0] j,
  output logic [DIM_W-1:0] k,
  output logic             k_last,
  output logic             j_last,
  output logic             last
);
  logic [DIM_W-1:0] i;
  logic             i_last;

  assign k_last = (k == dim_k - DIM_W'(1));
  assign j_last = (j == dim_n - DIM_W'(1));
  assign i_last = (i == dim_m - DIM_W'(1));
  assign last   = k_last && j_last && i_last;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      i <= '0;
      j <= '0;
      k <= '0;
    end else if (clear) begin
      i <= '0;
      j <= '0;
      k <= '0;
    end else if (en) begin
      if (!k_last) begin
        k <= k + DIM_W'(1);
      end else begin
        k <= '0;
        if (!j_last) begin
          j <= j + DIM_W'(1);
        end else begin
          j <= '0;
          i <= i_last ? '0 : i + DIM_W'(1);
        end
      end
    end
  end
endmodule

// File: rtl/pe_matmul_sequencer.sv
// Sequences one PE MAC datapath through C = A x B: loop counters, incremental
// A/B/C address offsets and the IDLE/RUN/FIN control FSM.
module pe_matmul_sequencer import pe_ctrl_pkg::*; #(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DIM_W  = DIM_W_DEF
) (
  input  logic                    clk,
  input  logic                    rst_n,
  pe_matmul_sequencer_if.slave    bus
);
  state_t            state, state_nx;
  cfg_t              cfg;
  logic              accept, adv, run;
  logic [ADDR_W-1:0] a_off, b_off, c_off;
  logic [DIM_W-1:0]  j_cnt, k_cnt;
  logic              k_last, j_last, last;

  always_comb begin
    state_nx = state;
    accept   = 1'b0;
    adv      = 1'b0;
    case (state)
      IDLE: if (bus.start) begin
        accept   = 1'b1;
        state_nx = any_zero(DIM_W_DEF'(bus.dim_m), DIM_W_DEF'(bus.dim_n),
                            DIM_W_DEF'(bus.dim_k)) ? FIN : RUN;
      end
      RUN: if (bus.step_fin) begin
        adv = 1'b1;
        if (last) state_nx = FIN;
      end
      FIN:     state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // Offsets are relative to the latched bases so the datapath only ever adds.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cfg   <= '0;
      a_off <= '0;
      b_off <= '0;
      c_off <= '0;
    end else if (accept) begin
      cfg.m      <= DIM_W_DEF'(bus.dim_m);
      cfg.n      <= DIM_W_DEF'(bus.dim_n);
      cfg.k      <= DIM_W_DEF'(bus.dim_k);
      cfg.base_a <= ADDR_W_DEF'(bus.base_a);
      cfg.base_b <= ADDR_W_DEF'(bus.base_b);
      cfg.base_c <= ADDR_W_DEF'(bus.base_c);
      a_off      <= '0;
      b_off      <= '0;
      c_off      <= '0;
    end else if (adv) begin
      if (k_last) begin
        b_off <= '0;
        c_off <= c_off + ADDR_W'(1);
        if (j_last) a_off <= a_off + ADDR_W'(cfg.k);
      end else begin
        b_off <= b_off + ADDR_W'(cfg.n);
      end
    end
  end

  pe_loop_counter #(.DIM_W(DIM_W)) u_cnt (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (accept),
    .en     (adv),
    .dim_m  (DIM_W'(cfg.m)),
    .dim_n  (DIM_W'(cfg.n)),
    .dim_k  (DIM_W'(cfg.k)),
    .j      (j_cnt),
    .k      (k_cnt),
    .k_last (k_last),
    .j_last (j_last),
    .last   (last)
  );

  assign run             = (state == RUN);
  assign bus.pe_active   = run;
  assign bus.pe_vec_fin  = run && k_last;
  assign bus.busy        = (state != IDLE);
  assign bus.done        = (state == FIN);
  assign bus.left_addr   = run ? ADDR_W'(cfg.base_a) + a_off + ADDR_W'(k_cnt) : '0;
  assign bus.right_addr  = run ? ADDR_W'(cfg.base_b) + b_off + ADDR_W'(j_cnt) : '0;
  assign bus.result_addr = run ? ADDR_W'(cfg.base_c) + c_off : '0;
endmodule

// File: tb/tb_pe_matmul_sequencer.sv
// Self-checking bench: golden 2x2x2 trace, table-driven scenarios and random
// configs checked against a nested-loop address model.
module tb_pe_matmul_sequencer;
  localparam int AW = 32;
  localparam int DW = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  pe_matmul_sequencer_if #(.ADDR_W(AW), .DIM_W(DW)) bus();
  pe_matmul_sequencer #(.ADDR_W(AW), .DIM_W(DW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  typedef struct {
    logic [AW-1:0] l, r, c;
    logic          vf;
  } term_t;
  term_t q[$];

  typedef struct {
    int            m, n, k;
    logic [AW-1:0] ba, bb, bc;
    int            stall_term, stall_len;
    bit            restart, rnd;
    int            exp_done, exp_writes;
  } vec_t;

  // Expected term stream straight from the matrix-index definition.
  task automatic build(input vec_t v);
    term_t t;
    q.delete();
    for (int i = 0; i < v.m; i++)
      for (int j = 0; j < v.n; j++)
        for (int kk = 0; kk < v.k; kk++) begin
          t.l  = v.ba + AW'(i * v.k + kk);
          t.r  = v.bb + AW'(kk * v.n + j);
          t.c  = v.bc + AW'(i * v.n + j);
          t.vf = (kk == v.k - 1);
          q.push_back(t);
        end
  endtask

  task automatic run(input vec_t v, output int done_cyc, output int writes, output int stalls);
    int  cyc, popped, stall_rem;
    bit  got_done, sf;
    build(v);
    done_cyc = -1; writes = 0; stalls = 0; popped = 0; stall_rem = v.stall_len; got_done = 0;
    @(negedge clk);
    bus.start = 1'b1; bus.step_fin = 1'b1;
    bus.dim_m = DW'(v.m); bus.dim_n = DW'(v.n); bus.dim_k = DW'(v.k);
    bus.base_a = v.ba; bus.base_b = v.bb; bus.base_c = v.bc;
    @(negedge clk);
    bus.start = 1'b0;
    bus.dim_m = DW'($urandom); bus.dim_n = DW'($urandom); bus.dim_k = DW'($urandom);
    bus.base_a = $urandom; bus.base_b = $urandom; bus.base_c = $urandom;
    cyc = 1;
    while (!got_done && cyc < 600) begin
      sf = 1'b1;
      if (popped == v.stall_term && stall_rem > 0) begin
        sf = 1'b0; stall_rem--;
      end else if (v.rnd && $urandom_range(0, 3) == 0) sf = 1'b0;
      bus.step_fin = sf;
      if (v.restart) begin
        bus.start = (cyc == 3);
        bus.dim_m = 1; bus.dim_n = 1; bus.dim_k = 1;
      end
      if (bus.pe_active) begin
        if (q.size() == 0) chk("extra_term", 1, 0);
        else begin
          chk("left_addr", bus.left_addr, q[0].l);
          chk("right_addr", bus.right_addr, q[0].r);
          chk("result_addr", bus.result_addr, q[0].c);
          chk("vec_fin", bus.pe_vec_fin, q[0].vf);
          chk("busy_run", bus.busy, 1);
          if (sf) begin
            if (q[0].vf) writes++;
            void'(q.pop_front());
            popped++;
          end else stalls++;
        end
      end
      if (bus.done) begin
        got_done = 1; done_cyc = cyc;
        chk("terms_left", q.size(), 0);
        chk("busy_fin", bus.busy, 1);
      end
      cyc++;
      @(negedge clk);
    end
    bus.start = 1'b0; bus.step_fin = 1'b1;
    if (!got_done) chk("done_timeout", 0, 1);
    chk("idle_busy", bus.busy, 0);
    chk("idle_done", bus.done, 0);
  endtask

  vec_t vt[6];
  vec_t rv;
  int   dc, wr, st;
  int   gl[8], gr[8], gc[8], gv[8];

  initial begin
    bus.start = 1'b0; bus.step_fin = 1'b1;
    bus.dim_m = '0; bus.dim_n = '0; bus.dim_k = '0;
    bus.base_a = '0; bus.base_b = '0; bus.base_c = '0;
    #1;
    chk("rst_active", bus.pe_active, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_vf", bus.pe_vec_fin, 0);
    chk("rst_left", bus.left_addr, 0);
    chk("rst_result", bus.result_addr, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Hand-written golden trace for the 2x2x2 case.
    gl = '{0, 1, 0, 1, 2, 3, 2, 3};
    gr = '{4, 6, 5, 7, 4, 6, 5, 7};
    gc = '{8, 8, 9, 9, 10, 10, 11, 11};
    gv = '{0, 1, 0, 1, 0, 1, 0, 1};
    @(negedge clk);
    bus.start = 1'b1; bus.dim_m = 2; bus.dim_n = 2; bus.dim_k = 2;
    bus.base_a = 0; bus.base_b = 4; bus.base_c = 8;
    chk("g_busy0", bus.busy, 0);
    @(negedge clk);
    bus.start = 1'b0;
    for (int c = 1; c <= 9; c++) begin
      chk("g_busy", bus.busy, 1);
      chk("g_done", bus.done, (c == 9));
      if (c <= 8) begin
        chk("g_left", bus.left_addr, gl[c-1]);
        chk("g_right", bus.right_addr, gr[c-1]);
        chk("g_result", bus.result_addr, gc[c-1]);
        chk("g_vf", bus.pe_vec_fin, gv[c-1]);
      end else chk("g_active_fin", bus.pe_active, 0);
      @(negedge clk);
    end
    chk("g_busy_end", bus.busy, 0);

    vt[0] = '{2, 2, 2, 0, 4, 8, -1, 0, 0, 0, 9, 4};
    vt[1] = '{1, 3, 1, 0, 10, 20, -1, 0, 0, 0, 4, 3};
    vt[2] = '{2, 0, 2, 0, 4, 8, -1, 0, 0, 0, 1, 0};
    vt[3] = '{2, 2, 2, 0, 4, 8, 1, 3, 0, 0, 12, 4};
    vt[4] = '{2, 2, 2, 0, 4, 8, -1, 0, 1, 0, 9, 4};
    vt[5] = '{2, 1, 3, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'hFFFF_FFFF, -1, 0, 0, 0, 7, 2};
    for (int t = 0; t < 6; t++) begin
      run(vt[t], dc, wr, st);
      chk($sformatf("vec%0d_done_cycle", t), dc, vt[t].exp_done);
      chk($sformatf("vec%0d_writes", t), wr, vt[t].exp_writes);
    end

    // Asynchronous reset between edges in the middle of a run.
    @(negedge clk);
    bus.start = 1'b1; bus.dim_m = 3; bus.dim_n = 3; bus.dim_k = 3;
    bus.base_a = 100; bus.base_b = 200; bus.base_c = 300;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (4) @(negedge clk);
    chk("pre_rst_active", bus.pe_active, 1);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_active", bus.pe_active, 0);
    chk("mid_rst_busy", bus.busy, 0);
    chk("mid_rst_vf", bus.pe_vec_fin, 0);
    chk("mid_rst_result", bus.result_addr, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_busy", bus.busy, 0);
    run(vt[0], dc, wr, st);
    chk("post_rst_done_cycle", dc, 9);

    for (int r = 0; r < 8; r++) begin
      rv = '{0, 0, 0, 0, 0, 0, -1, 0, 0, 1, 0, 0};
      rv.m = $urandom_range(1, 3); rv.n = $urandom_range(1, 3);
      rv.k = $urandom_range(1, 4);
      if (r == 5) rv.k = 0;
      rv.ba = $urandom; rv.bb = $urandom; rv.bc = $urandom;
      run(rv, dc, wr, st);
      if (rv.k == 0) chk("rnd_zero_done", dc, 1);
      else begin
        chk("rnd_done_cycle", dc, rv.m * rv.n * rv.k + st + 1);
        chk("rnd_writes", wr, rv.m * rv.n);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
